// File: rtl/minmax_scan_sequencer.sv
// Windowed min/max scanner: accepts (base, len) jobs and streams one read address per cycle into the scan memory.
// Latency: first read 1 cycle after acceptance; result valid len+2 cycles after acceptance (1 cycle when len=0).
// Backpressure: job_ready is low outside IDLE; a result is held stable in RESULT until res_ready.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   job_valid/job_ready        job handshake; job_base/job_len are sampled at the acceptance edge
//   ADDR, mem_en, DATA         memory read port; DATA answers the previous cycle's ADDR/mem_en
//   res_valid/res_ready        result handshake
//   MAX, MIN                   result values
//   max_addr, min_addr         first-occurrence addresses of MAX and MIN
//   empty                      the job had job_len = 0
module minmax_scan_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_base,
    input  logic [ADDR_WIDTH:0]   job_len,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] MAX,
    output logic [DATA_WIDTH-1:0] MIN,
    output logic [ADDR_WIDTH-1:0] max_addr,
    output logic [ADDR_WIDTH-1:0] min_addr,
    output logic                  empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_RESULT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = 0;

    state_t                  state;
    logic [ADDR_WIDTH:0]     remaining;

    // Fold stage: one cycle behind issue, since DATA answers last cycle's read.
    logic                    fold_vld;
    logic [ADDR_WIDTH-1:0]   fold_addr;
    logic                    fold_first;

    // Running accumulators, kept separate from the result outputs so the
    // outputs only move when the job finishes.
    logic [DATA_WIDTH-1:0]   run_max;
    logic [DATA_WIDTH-1:0]   run_min;
    logic [ADDR_WIDTH-1:0]   run_max_addr;
    logic [ADDR_WIDTH-1:0]   run_min_addr;

    logic [DATA_WIDTH-1:0]   nxt_max;
    logic [DATA_WIDTH-1:0]   nxt_min;
    logic [ADDR_WIDTH-1:0]   nxt_max_addr;
    logic [ADDR_WIDTH-1:0]   nxt_min_addr;

    // Strict comparisons so ties keep the earlier (first) address.
    always_comb begin
        nxt_max      = run_max;
        nxt_min      = run_min;
        nxt_max_addr = run_max_addr;
        nxt_min_addr = run_min_addr;
        if (fold_first) begin
            nxt_max      = DATA;
            nxt_min      = DATA;
            nxt_max_addr = fold_addr;
            nxt_min_addr = fold_addr;
        end else begin
            if (DATA > run_max) begin
                nxt_max      = DATA;
                nxt_max_addr = fold_addr;
            end
            if (DATA < run_min) begin
                nxt_min      = DATA;
                nxt_min_addr = fold_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            job_ready    <= 1'b1;
            mem_en       <= 1'b0;
            ADDR         <= '0;
            res_valid    <= 1'b0;
            MAX          <= '0;
            MIN          <= '0;
            max_addr     <= '0;
            min_addr     <= '0;
            empty        <= 1'b0;
            remaining    <= '0;
            fold_vld     <= 1'b0;
            fold_addr    <= '0;
            fold_first   <= 1'b0;
            run_max      <= '0;
            run_min      <= '0;
            run_max_addr <= '0;
            run_min_addr <= '0;
        end else begin
            fold_vld  <= mem_en;
            fold_addr <= ADDR;

            if (fold_vld) begin
                run_max      <= nxt_max;
                run_min      <= nxt_min;
                run_max_addr <= nxt_max_addr;
                run_min_addr <= nxt_min_addr;
                fold_first   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        job_ready <= 1'b0;
                        if (job_len == LEN_ZERO) begin
                            state     <= S_RESULT;
                            res_valid <= 1'b1;
                            empty     <= 1'b1;
                            MAX       <= '0;
                            MIN       <= '1;
                            max_addr  <= job_base;
                            min_addr  <= job_base;
                        end else begin
                            state      <= S_READ;
                            mem_en     <= 1'b1;
                            ADDR       <= job_base;
                            remaining  <= job_len;
                            fold_first <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    if (remaining == LEN_ONE) begin
                        state  <= S_DRAIN;
                        mem_en <= 1'b0;
                    end else begin
                        // Natural ADDR_WIDTH overflow gives the wrap to 0.
                        ADDR      <= ADDR + ADDR_ONE;
                        remaining <= remaining - LEN_ONE;
                    end
                end

                S_DRAIN: begin
                    // Last word is on DATA now; publish the folded result directly.
                    state     <= S_RESULT;
                    res_valid <= 1'b1;
                    empty     <= 1'b0;
                    MAX       <= nxt_max;
                    MIN       <= nxt_min;
                    max_addr  <= nxt_max_addr;
                    min_addr  <= nxt_min_addr;
                end

                S_RESULT: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_scan_sequencer.sv
module tb_minmax_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [9:0]  job_base = '0;
    logic [10:0] job_len = '0;
    logic [9:0]  ADDR;
    logic        mem_en;
    logic [7:0]  DATA = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  MAX;
    logic [7:0]  MIN;
    logic [9:0]  max_addr;
    logic [9:0]  min_addr;
    logic        empty;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:1023];
    int         issue_q[$];
    logic [7:0] prev_max = '0;
    logic [7:0] prev_min = '0;

    minmax_scan_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_base(job_base), .job_len(job_len),
        .ADDR(ADDR), .mem_en(mem_en), .DATA(DATA),
        .res_valid(res_valid), .res_ready(res_ready),
        .MAX(MAX), .MIN(MIN), .max_addr(max_addr), .min_addr(min_addr),
        .empty(empty)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data returns the cycle after the address.
    always @(posedge clk) if (mem_en) DATA <= mem[ADDR];

    // Record every issued read address.
    always @(negedge clk) if (mem_en) issue_q.push_back(int'(ADDR));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int maxv);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, maxv));
    endtask

    // Drives one job, checks latency, issued addresses and results against a
    // straightforward scan of the window, holds the result for `hold` cycles,
    // then completes the handshake.
    task automatic run_job(input int base, input int len, input int hold);
        int         cyc;
        bit         got;
        logic [7:0] emx, emn, v;
        int         emxa, emna, a;
        logic [63:0] snap;

        emx = 8'h00; emn = 8'hFF; emxa = base; emna = base;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % 1024;
            v = mem[a];
            if (i == 0 || v > emx) begin emx = v; emxa = a; end
            if (i == 0 || v < emn) begin emn = v; emna = a; end
        end

        @(negedge clk);
        check("job_ready_idle", job_ready, 1);
        issue_q.delete();
        job_base  = 10'(base);
        job_len   = 11'(len);
        job_valid = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        job_base  = 10'($urandom);
        job_len   = 11'($urandom);

        cyc = 0; got = 0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("job_ready_busy", job_ready, 0);
                if (len > 0) check("result_held_prev", {MAX, MIN}, {prev_max, prev_min});
            end
            if (res_valid) begin
                got = 1;
                res_ready = 1'b0;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
        end
        check("latency", cyc, (len == 0) ? 1 : len + 2);
        check("res_valid", res_valid, 1);
        check("MAX", MAX, emx);
        check("MIN", MIN, emn);
        check("max_addr", max_addr, emxa);
        check("min_addr", min_addr, emna);
        check("empty", empty, (len == 0) ? 1 : 0);
        check("issue_count", issue_q.size(), len);
        for (int i = 0; i < issue_q.size() && i < len; i++)
            if (issue_q[i] != (base + i) % 1024) check("issue_addr", issue_q[i], (base + i) % 1024);

        snap = {MAX, MIN, max_addr, min_addr, empty};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            job_valid = (i == 5);
            check("hold_stable", {MAX, MIN, max_addr, min_addr, empty}, snap);
            check("hold_busy", {res_valid, job_ready}, 2'b10);
        end
        job_valid = 1'b0;

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_handshake", {res_valid, job_ready}, 2'b01);
        check("post_handshake_keep", {MAX, MIN}, {emx, emn});
        prev_max = emx;
        prev_min = emn;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_job_ready", job_ready, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_ADDR", ADDR, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_results", {MAX, MIN, max_addr, min_addr, empty}, 0);

        // Full-memory ramp.
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 256);
        run_job(0, 1024, 0);

        // Wrap with a tie on the maximum.
        fill_random(255);
        mem[1022] = 8'd5; mem[1023] = 8'd200; mem[0] = 8'd3; mem[1] = 8'd200;
        run_job(1022, 4, 0);

        // Empty job.
        run_job(17, 0, 0);

        // Backpressure with an ignored job pulse.
        run_job($urandom_range(0, 1023), $urandom_range(1, 40), 20);

        // Single word.
        mem[500] = 8'h7F;
        run_job(500, 1, 0);

        // Reset during READ.
        fill_random(255);
        @(negedge clk);
        job_base = 10'd300; job_len = 11'd100; job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_job_reading", mem_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_mem_en", mem_en, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_job_ready", job_ready, 1);
        check("abort_results", {MAX, MIN}, 0);
        prev_max = '0; prev_min = '0;
        run_job(900, 200, 0);

        // Randomised jobs, some over a narrow value range to create ties.
        for (int j = 0; j < 8; j++) begin
            fill_random((j % 2) ? 3 : 255);
            run_job($urandom_range(0, 1023), $urandom_range(0, 80), $urandom_range(0, 4));
        end
        fill_random(255);
        run_job($urandom_range(0, 1023), 1024, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minmax_scan_sequencer.md
# minmax_scan_sequencer

Job-driven controller that owns the read port of the 1 KiB scan memory and runs min/max scans over arbitrary address windows. A host issues jobs (base address, length) over a valid/ready handshake. The block streams one address per cycle into the memory, folds the returned bytes into running min/max values and first-occurrence addresses, and returns each result over a second valid/ready handshake. It sits between the host and the memory, replacing fixed full-memory scans with windowed, back-to-back jobs.

## Interface
Parameters:
- ADDR_WIDTH, 10, memory address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 8, memory word width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  host presents a job
- job_ready  out  1  block accepts a job this cycle
- job_base  in  ADDR_WIDTH  first address of the window
- job_len  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
- ADDR  out  ADDR_WIDTH  memory read address
- mem_en  out  1  ADDR is a valid read this cycle
- DATA  in  DATA_WIDTH  read data for the ADDR/mem_en of the previous cycle
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- MAX  out  DATA_WIDTH  maximum value in window
- MIN  out  DATA_WIDTH  minimum value in window
- max_addr  out  ADDR_WIDTH  address of first occurrence of MAX
- min_addr  out  ADDR_WIDTH  address of first occurrence of MIN
- empty  out  1  job had job_len = 0

## Operation
- States: IDLE, READ, DRAIN, RESULT.
- IDLE: job_ready=1. On job_valid&job_ready, latch base and len.
  - len=0: go to RESULT with empty=1, MAX=0, MIN=all-ones, max_addr=min_addr=base.
  - Otherwise go to READ with issue pointer=base, remaining=len.
- READ: mem_en=1, ADDR=issue pointer. The pointer increments mod 2^ADDR_WIDTH, so a window wraps 1023->0. remaining decrements each cycle. When remaining reaches 1 (last issue this cycle), go to DRAIN.
- Fold stage runs one cycle behind issue, using a delayed address and valid:
  - First word of the job initialises MAX=MIN=DATA and both addrs to its address.
  - Later words: update MAX only if DATA > MAX (strict); update MIN only if DATA < MIN (strict). Ties keep the earlier address.
- DRAIN: mem_en=0. Fold the last word, then go to RESULT.
- RESULT: res_valid=1. MAX, MIN, addrs and empty are held stable until res_valid&res_ready, then return to IDLE. job_ready=0 outside IDLE, so no jobs queue.
- Comparisons are unsigned DATA_WIDTH.
- len=2^ADDR_WIDTH covers the whole memory exactly once.

## Timing
- Reset (rst=1 at an edge) forces IDLE with these values: job_ready=1 after release, mem_en=0, ADDR=0, res_valid=0, MAX=0, MIN=0, addrs=0, empty=0.
- Reset mid-job aborts the job with no result, and any in-flight read data is discarded.
- Acceptance at edge T:
  - First ADDR/mem_en at cycle T+1.
  - Last issue at T+len.
  - DRAIN at T+len+1.
  - res_valid=1 from T+len+2.
  - len=0: res_valid=1 at T+1.
- Result outputs change only on entering RESULT or on reset. Outside RESULT they hold the previous job's values.
- res_ready sampled while res_valid=0 has no effect.
- Back-to-back throughput is len+3 cycles per job when res_ready is held 1: RESULT returns to IDLE on the handshake edge, and the next job is accepted one cycle later.
- job_base/job_len are sampled only at the acceptance edge. Later changes are ignored.

## Test plan
- Memory filled with mem[i]=i mod 256, job base=0, len=1024, res_ready=1 → res_valid at accept+1026, MAX=255 at addr 255, MIN=0 at addr 0, ADDR sequence 0..1023 with mem_en high for exactly 1024 cycles.
- Wrap: mem[1022]=5, mem[1023]=200, mem[0]=3, mem[1]=200, job base=1022, len=4 → ADDR 1022,1023,0,1; MAX=200 at max_addr=1023 (first occurrence); MIN=3 at min_addr=0.
- job_len=0 with base=17 → res_valid at next cycle, empty=1, MAX=0, MIN=255, addrs=17, mem_en never asserted.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid → outputs stable, job_ready=0, a job_valid pulse is ignored. Raise res_ready → IDLE next cycle, job accepted the cycle after.
- Single word: base=500, len=1, mem[500]=0x7F → MAX=MIN=0x7F, both addrs=500, res_valid at accept+3.
- Reset during READ (cycle 10 of a len=100 job) → next cycle mem_en=0, res_valid=0, job_ready=1. A fresh job then completes with correct results unaffected by the aborted job.
